mbs_fsk_demod: RTL and testbench
================================

// Module: mbs_fsk_demod
// PURPOSE
//  Receive side of the multi-bit-symbol FSK link. Takes the 1-bit quadrature pair (IN_REAL/IN_IMAG, i.e. far-end GPIO2/GPIO1).
//  Counts signed quadrant rotations over each symbol window, converts the count to tone cycles, and emits the 5-bit symbol index.
//  Sits beside the transmitter in loopback; its SYMBOL stream is compared against the LFSR sequence for BER.
// PARAMETERS
//  SAMP_DIV   1    sample strobe every SAMP_DIV clocks (1 = every clk)
//  WINDOW     128  samples per symbol window (power of 2)
//  TONE_BASE  1    tone cycles per window for symbol 0; symbol s = TONE_BASE+s cycles
//  AMB_MAX    4    max ambiguous (180 deg) steps per window before ERROR
// PORTS
//  clk      in   1  system clock (16 MHz)
//  reset    in   1  synchronous, active-high reset
//  IN_REAL  in   1  async in-phase bit; 2-FF synchronised internally
//  IN_IMAG  in   1  async quadrature bit; 2-FF synchronised internally
//  ALIGN    in   1  1-clk pulse: restart window at next sample (delayed 2 clk internally to match sync path)
//  SYMBOL   out  5  decoded symbol, held until next VALID
//  VALID    out  1  1-clk pulse: SYMBOL/ERROR updated
//  ERROR    out  1  window failed range/ambiguity check, held with SYMBOL
//  QCOUNT   out  9  signed quadrant-step total of last window (debug)
// BEHAVIOUR
//  Reset: SYMBOL=0, VALID=0, ERROR=0, QCOUNT=0; sample counter=0, accumulator=0, amb count=0, first-sample flag set.
//  Reset applies mid-window: partial window dropped, no VALID.
//  Quadrant q from synced {I,Q}: 11->0, 01->1, 00->2, 10->3 (CCW positive).
//  Per sample strobe, d=(q-q_prev) mod 4: 0->0, 1->+1, 3->-1, 2->0 and amb_cnt++.
//  First sample of a window only loads q_prev; window spans WINDOW samples = WINDOW-1 steps.
//  Accumulator: 9-bit signed, no wrap possible (|acc| <= 127).
//  End of window (sample index WINDOW-1 processed):
//   - cycles = (acc+2)>>>2 (arithmetic shift, round-half-up)
//   - idx = cycles-TONE_BASE
//   - ERROR=1 if idx<0, idx>31, or amb_cnt>AMB_MAX; otherwise ERROR=0
//   - SYMBOL=idx[4:0] if no error, else 0
//   - QCOUNT=acc; VALID pulses; acc/amb_cnt clear; next window begins.
//  Latency: VALID high exactly 4 clk after the clk presenting the window's last raw input sample (SAMP_DIV=1): 2 sync + 1 quadrant reg + 1 output reg.
//  ALIGN: counter->0, acc/amb clear, first-sample flag set; no VALID for aborted window.
//   - ALIGN coincident with end-of-window: end-of-window result still issued (VALID), new window starts fresh.
//   - ALIGN during reset: ignored.
//  States: SYNC_WAIT (after reset until first strobe), ACCUM, EMIT (1 clk).
//   - EMIT->ACCUM on the following strobe; sampling is never stalled.
//  SAMP_DIV>1: strobe counter free-runs; ALIGN also resets it.
// STRUCTURE
//  Package mbsfsk_pkg: quadrant encoding localparams, SYMB_W=5, ACC_W=9, default WINDOW.
//  Sub-module fsk_quad_step: registered q/q_prev, outputs step {-1,0,+1} and amb flag.
//  Top holds sync FFs, strobe/window counters, accumulator, FSM, output regs.
// TESTING
//  1 Reset 4 clk with inputs toggling -> SYMBOL=0, VALID=0, ERROR=0, QCOUNT=0.
//  2 ALIGN then ideal CCW tone, 1 cycle/128 samples -> VALID 4 clk after sample 127; SYMBOL=0, ERROR=0, QCOUNT=3.
//  3 Ideal CCW tone, 32 cycles (1 quadrant/sample) -> SYMBOL=31, ERROR=0, QCOUNT=127.
//  4 Clockwise 5-cycle tone (I/Q swapped) -> ERROR=1, SYMBOL=0, QCOUNT=-19; alternating 11/00 input -> ERROR=1 (amb).
//  5 ALIGN at sample 60 of a window -> no VALID for that window; next VALID 128 samples + 4 clk after ALIGN.
//  6 Transmitter GPIO2/GPIO1 looped to IN_REAL/IN_IMAG, 64 windows, aligned to its SHIFT -> SYMBOL sequence equals LFSR sequence, ERROR never set.

Source files
------------

// File: rtl/mbs_fsk_demod_pkg.sv
// Shared constants, state encoding and quadrant lookup for the multi-bit-symbol FSK demodulator.
package mbsfsk_pkg;

    localparam logic [1:0] QUAD_0 = 2'd0;
    localparam logic [1:0] QUAD_1 = 2'd1;
    localparam logic [1:0] QUAD_2 = 2'd2;
    localparam logic [1:0] QUAD_3 = 2'd3;

    localparam int SYMB_W     = 5;
    localparam int ACC_W      = 9;
    localparam int AMB_W      = 8;
    localparam int DEF_WINDOW = 128;

    typedef enum logic [1:0] {
        SYNC_WAIT,
        ACCUM,
        EMIT
    } demod_state_e;

    // {I,Q} -> quadrant index, counter-clockwise rotation counts upward
    function automatic logic [1:0] quadOf(input logic [1:0] iq);
        logic [1:0] quad;
        case (iq)
            2'b11:   quad = QUAD_0;
            2'b01:   quad = QUAD_1;
            2'b00:   quad = QUAD_2;
            default: quad = QUAD_3;
        endcase
        return quad;
    endfunction

endpackage

// File: rtl/mbs_fsk_demod_if.sv
// Link-side signal bundle of the FSK demodulator: quadrature inputs, ALIGN and decoded results.
interface mbs_fsk_demod_if;
    import mbsfsk_pkg::*;

    logic                     IN_REAL;
    logic                     IN_IMAG;
    logic                     ALIGN;
    logic [SYMB_W-1:0]        SYMBOL;
    logic                     VALID;
    logic                     ERROR;
    logic [ACC_W-1:0]         QCOUNT;

    modport master (
        output IN_REAL, IN_IMAG, ALIGN,
        input  SYMBOL, VALID, ERROR, QCOUNT
    );

    modport slave (
        input  IN_REAL, IN_IMAG, ALIGN,
        output SYMBOL, VALID, ERROR, QCOUNT
    );

endinterface

// File: rtl/mbs_fsk_demod_quad_step.sv
// Registers the current and previous quadrant and classifies each sample-to-sample rotation.
module fsk_quad_step
    import mbsfsk_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              sampleEn_i,
    input  logic [1:0]        iq_i,
    output logic signed [1:0] step_o,
    output logic              amb_o
);

    logic [1:0] quad_q;
    logic [1:0] quadPrev_q;
    logic [1:0] quadDiff;

    always_ff @(posedge clk) begin
        if (reset) begin
            quad_q     <= QUAD_0;
            quadPrev_q <= QUAD_0;
        end else if (sampleEn_i) begin
            quad_q     <= quadOf(iq_i);
            quadPrev_q <= quad_q;
        end
    end

    // A half-turn cannot be told apart from either direction, so it scores zero and is flagged
    always_comb begin
        step_o   = 2'sd0;
        amb_o    = 1'b0;
        quadDiff = quad_q - quadPrev_q;
        case (quadDiff)
            2'd1:    step_o = 2'sd1;
            2'd3:    step_o = -2'sd1;
            2'd2:    amb_o  = 1'b1;
            default: step_o = 2'sd0;
        endcase
    end

endmodule

// File: rtl/mbs_fsk_demod.sv
// FSK receive path: synchronises the quadrature pair, counts signed quadrant steps per window
// and converts the total into a tone-cycle symbol index with range/ambiguity checking.
module mbs_fsk_demod
    import mbsfsk_pkg::*;
#(
    parameter int SAMP_DIV  = 1,
    parameter int WINDOW    = DEF_WINDOW,
    parameter int TONE_BASE = 1,
    parameter int AMB_MAX   = 4
)(
    input  logic             clk,
    input  logic             reset,
    mbs_fsk_demod_if.slave   bus
);

    localparam int DIV_W = (SAMP_DIV > 1) ? $clog2(SAMP_DIV) : 1;
    localparam int CNT_W = $clog2(WINDOW) + 1;
    localparam int RND_W = ACC_W + 1;

    localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(SAMP_DIV - 1);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(WINDOW - 1);
    localparam logic [AMB_W-1:0]        AMB_LIM  = AMB_W'(AMB_MAX);
    localparam logic signed [RND_W-1:0] BASE_S   = RND_W'(TONE_BASE);
    localparam logic signed [RND_W-1:0] IDX_MAX  = RND_W'((1 << SYMB_W) - 1);

    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic             pendAlign_q, pendAlign_d;
    logic             sampleStrobe;

    logic [1:0] sync1_q, sync2_q;
    logic       stb1_q, stb2_q, stb3_q;
    logic       first1_q, first2_q, first3_q;

    logic signed [1:0] step;
    logic              amb;

    demod_state_e             state_q, state_d;
    logic [CNT_W-1:0]         winCnt_q, winCnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [AMB_W-1:0]         ambCnt_q, ambCnt_d;
    logic                     firstSamp_q, firstSamp_d;
    logic [SYMB_W-1:0]        symbol_q, symbol_d;
    logic                     valid_q, valid_d;
    logic                     error_q, error_d;
    logic signed [ACC_W-1:0]  qcount_q, qcount_d;

    logic signed [ACC_W-1:0]  stepExt, accSum;
    logic [AMB_W-1:0]         ambSum;
    logic signed [RND_W-1:0]  roundCyc, symIdx;
    logic                     windowBad;

    assign sampleStrobe = (divCnt_q == '0);

    // ALIGN is held pending until the next strobe, and that sample is tagged as a window start
    always_comb begin
        divCnt_d    = divCnt_q;
        pendAlign_d = pendAlign_q;
        if (bus.ALIGN) begin
            divCnt_d = '0;
        end else if (divCnt_q == DIV_LAST) begin
            divCnt_d = '0;
        end else begin
            divCnt_d = divCnt_q + DIV_W'(1);
        end
        if (bus.ALIGN) begin
            pendAlign_d = 1'b1;
        end else if (sampleStrobe) begin
            pendAlign_d = 1'b0;
        end
    end

    // The strobe and start tag ride alongside the data through the synchroniser and quadrant register
    always_ff @(posedge clk) begin
        if (reset) begin
            divCnt_q    <= '0;
            pendAlign_q <= 1'b0;
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            stb1_q      <= 1'b0;
            stb2_q      <= 1'b0;
            stb3_q      <= 1'b0;
            first1_q    <= 1'b0;
            first2_q    <= 1'b0;
            first3_q    <= 1'b0;
        end else begin
            divCnt_q    <= divCnt_d;
            pendAlign_q <= pendAlign_d;
            sync1_q     <= {bus.IN_REAL, bus.IN_IMAG};
            sync2_q     <= sync1_q;
            stb1_q      <= sampleStrobe;
            stb2_q      <= stb1_q;
            stb3_q      <= stb2_q;
            first1_q    <= sampleStrobe & pendAlign_q;
            first2_q    <= first1_q;
            first3_q    <= first2_q;
        end
    end

    fsk_quad_step u_quadStep (
        .clk        (clk),
        .reset      (reset),
        .sampleEn_i (stb2_q),
        .iq_i       (sync2_q),
        .step_o     (step),
        .amb_o      (amb)
    );

    // Round-half-up divide by four turns quadrant steps into whole tone cycles
    always_comb begin
        stepExt   = ACC_W'(step);
        accSum    = acc_q + stepExt;
        ambSum    = ambCnt_q + {{(AMB_W-1){1'b0}}, amb};
        roundCyc  = (RND_W'(accSum) + RND_W'(2)) >>> 2;
        symIdx    = roundCyc - BASE_S;
        windowBad = (symIdx < 0) || (symIdx > IDX_MAX) || (ambSum > AMB_LIM);
    end

    always_comb begin
        state_d     = state_q;
        winCnt_d    = winCnt_q;
        acc_d       = acc_q;
        ambCnt_d    = ambCnt_q;
        firstSamp_d = firstSamp_q;
        symbol_d    = symbol_q;
        valid_d     = 1'b0;
        error_d     = error_q;
        qcount_d    = qcount_q;

        if (stb3_q) begin
            if (first3_q || firstSamp_q) begin
                acc_d       = '0;
                ambCnt_d    = '0;
                winCnt_d    = CNT_W'(1);
                firstSamp_d = 1'b0;
            end else if (winCnt_q == CNT_LAST) begin
                valid_d     = 1'b1;
                error_d     = windowBad;
                symbol_d    = windowBad ? '0 : symIdx[SYMB_W-1:0];
                qcount_d    = accSum;
                acc_d       = '0;
                ambCnt_d    = '0;
                winCnt_d    = '0;
                firstSamp_d = 1'b1;
            end else begin
                acc_d       = accSum;
                ambCnt_d    = ambSum;
                winCnt_d    = winCnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            SYNC_WAIT: if (stb3_q)  state_d = ACCUM;
            ACCUM:     if (valid_d) state_d = EMIT;
            EMIT:      if (stb3_q)  state_d = valid_d ? EMIT : ACCUM;
            default:                state_d = SYNC_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SYNC_WAIT;
            winCnt_q    <= '0;
            acc_q       <= '0;
            ambCnt_q    <= '0;
            firstSamp_q <= 1'b1;
            symbol_q    <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            qcount_q    <= '0;
        end else begin
            state_q     <= state_d;
            winCnt_q    <= winCnt_d;
            acc_q       <= acc_d;
            ambCnt_q    <= ambCnt_d;
            firstSamp_q <= firstSamp_d;
            symbol_q    <= symbol_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
            qcount_q    <= qcount_d;
        end
    end

    assign bus.SYMBOL = symbol_q;
    assign bus.VALID  = valid_q;
    assign bus.ERROR  = error_q;
    assign bus.QCOUNT = qcount_q;

endmodule

// File: tb/tb_mbs_fsk_demod.sv
// Scoreboard bench for mbs_fsk_demod: synthesises quadrature tones per window and checks each decoded result and its latency.
module tb_mbs_fsk_demod;
    import mbsfsk_pkg::*;

    typedef struct {
        logic [4:0] sym;
        logic       err;
        logic [8:0] qc;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   nVec = 0;
    int   nMiss = 0;
    exp_t sb[$];
    exp_t expItem;
    logic [4:0] lfsr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mbs_fsk_demod_if bus();

    mbs_fsk_demod #(
        .SAMP_DIV  (1),
        .WINDOW    (128),
        .TONE_BASE (1),
        .AMB_MAX   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nVec++;
        if (obs !== expv) begin
            nMiss++;
            $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic logic [1:0] iqOf(input int q);
        logic [1:0] iq;
        case (q & 3)
            0:       iq = 2'b11;
            1:       iq = 2'b01;
            2:       iq = 2'b00;
            default: iq = 2'b10;
        endcase
        return iq;
    endfunction

    // Ideal tone: 'cycles' turns over 128 samples is cycles/32 quadrants per sample
    function automatic int toneQuad(input int cycles, input int n);
        return (n * cycles) / 32;
    endfunction

    task automatic driveSample(input logic [1:0] iq, input logic al);
        @(posedge clk);
        #1;
        bus.IN_REAL = iq[1];
        bus.IN_IMAG = iq[0];
        bus.ALIGN   = al;
    endtask

    // kind: 0 CCW tone, 1 CW tone, 2 alternating half-turns, 3 tone + 2 glitches, 4 tone + 3 glitches
    task automatic applyStimulus(input int kind, input int cycles, input int nSamp, input int alignAt,
                                 input bit doPush, input logic [4:0] eSym, input logic eErr,
                                 input logic [8:0] eQc);
        for (int n = 0; n < nSamp; n++) begin
            int q;
            case (kind)
                0:       q = toneQuad(cycles, n);
                1:       q = -toneQuad(cycles, n);
                2:       q = (n % 2 == 1) ? 2 : 0;
                default: begin
                    q = toneQuad(cycles, n);
                    if (n == 5 || n == 40 || (kind == 4 && n == 127)) q = q + 2;
                end
            endcase
            driveSample(iqOf(q), (n == alignAt));
            if (doPush && n == 127) sb.push_back('{eSym, eErr, eQc, cyc + 4});
        end
    endtask

    always @(negedge clk) begin
        if (bus.VALID === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("spuriousValid", 32'd1, 32'd0);
            end else begin
                expItem = sb.pop_front();
                checkOutput("symbol",  {27'd0, bus.SYMBOL}, {27'd0, expItem.sym});
                checkOutput("error",   {31'd0, bus.ERROR},  {31'd0, expItem.err});
                checkOutput("qcount",  {23'd0, bus.QCOUNT}, {23'd0, expItem.qc});
                checkOutput("latency", cyc, expItem.cyc);
            end
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL globalTimeout: got no finish, want finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        reset       = 1'b1;
        bus.IN_REAL = 1'b0;
        bus.IN_IMAG = 1'b0;
        bus.ALIGN   = 1'b0;

        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            bus.IN_REAL = i[0];
            bus.IN_IMAG = ~i[1];
            bus.ALIGN   = i[0];
        end
        @(negedge clk);
        checkOutput("rstSymbol", {27'd0, bus.SYMBOL}, 32'd0);
        checkOutput("rstValid",  {31'd0, bus.VALID},  32'd0);
        checkOutput("rstError",  {31'd0, bus.ERROR},  32'd0);
        checkOutput("rstQcount", {23'd0, bus.QCOUNT}, 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.ALIGN = 1'b0;

        driveSample(2'b11, 1'b1);
        applyStimulus(0, 1,   128, -1, 1'b1, 5'd0,  1'b0, 9'd3);
        applyStimulus(0, 32,  128, -1, 1'b1, 5'd31, 1'b0, 9'd127);
        applyStimulus(1, 5,   128, -1, 1'b1, 5'd0,  1'b1, -9'sd19);
        applyStimulus(2, 0,   128, -1, 1'b1, 5'd0,  1'b1, 9'd0);
        applyStimulus(3, 2,   128, -1, 1'b1, 5'd1,  1'b0, 9'd7);
        applyStimulus(4, 2,   128, -1, 1'b1, 5'd0,  1'b1, 9'd7);
        applyStimulus(0, 4,   128, 127, 1'b1, 5'd3, 1'b0, 9'd15);
        applyStimulus(0, 8,   61,  60, 1'b0, 5'd0,  1'b0, 9'd0);
        applyStimulus(0, 3,   128, -1, 1'b1, 5'd2,  1'b0, 9'd11);

        applyStimulus(0, 6, 50, -1, 1'b0, 5'd0, 1'b0, 9'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midRstSymbol", {27'd0, bus.SYMBOL}, 32'd0);
        checkOutput("midRstValid",  {31'd0, bus.VALID},  32'd0);
        checkOutput("midRstQcount", {23'd0, bus.QCOUNT}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        driveSample(2'b11, 1'b1);
        lfsr = 5'b00001;
        for (int w = 0; w < 64; w++) begin
            applyStimulus(0, int'(lfsr) + 1, 128, -1, 1'b1, lfsr, 1'b0,
                          9'((127 * (int'(lfsr) + 1)) / 32));
            lfsr = {lfsr[3:0], lfsr[4] ^ lfsr[2]};
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        checkOutput("drainPending", sb.size(), 32'd0);
        repeat (8) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
